// File: rtl/mult_div_unit_if.sv
// Pipeline-control <-> multiply/divide unit bundle; master is the pipeline, slave is the unit.
// Abort exists only when MDU_ABORT_EN is defined.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
`ifdef MDU_ABORT_EN
    logic             Abort;
`endif
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             HiWriteEnable;
    logic             LoWriteEnable;
    logic             DivByZero;

    modport master (
`ifdef MDU_ABORT_EN
        output Abort,
`endif
        output Start, Op, OperandA, OperandB,
        input  Busy, Done, HiOut, LoOut, HiWriteEnable, LoWriteEnable, DivByZero
    );

    modport slave (
`ifdef MDU_ABORT_EN
        input  Abort,
`endif
        input  Start, Op, OperandA, OperandB,
        output Busy, Done, HiOut, LoOut, HiWriteEnable, LoWriteEnable, DivByZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers; optional MDU_ABORT_EN adds Abort.
// Latency: Done one cycle after edge Start+WIDTH+2 (WIDTH ITER steps + 1 drain, 1 FIX, 1 DONE).
// Backpressure: none; pipeline stalls on Busy, Start is honoured only in IDLE.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic             is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] b_reg, hi_acc, lo_acc;
    logic [WIDTH-1:0] hi_out_q, lo_out_q;
    logic             dbz_q;
    logic             abort_hit;

    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix;

`ifdef MDU_ABORT_EN
    assign abort_hit = bus.Abort && (state == ITER || state == FIX);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = ITER;
            ITER:    if (count == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // Signed ops run on magnitudes; signs are reapplied in FIX.
    assign op_signed = ~bus.Op[0];
    assign a_neg     = op_signed & bus.OperandA[WIDTH-1];
    assign b_neg     = op_signed & bus.OperandB[WIDTH-1];
    assign a_mag     = a_neg ? -bus.OperandA : bus.OperandA;
    assign b_mag     = b_neg ? -bus.OperandB : bus.OperandB;

    assign mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
    assign div_shift = {hi_acc, lo_acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_ge    = ~div_diff[WIDTH];

    assign prod      = {hi_acc, lo_acc};
    assign prod_fix  = neg_q ? -prod : prod;
    assign q_fix     = neg_q ? -lo_acc : lo_acc;
    assign r_fix     = neg_r ? -hi_acc : hi_acc;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            b_reg    <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Start) begin
                    is_div   <= bus.Op[1];
                    neg_q    <= a_neg ^ b_neg;
                    neg_r    <= a_neg;
                    div_zero <= (bus.OperandB == '0);
                    count    <= '0;
                    hi_acc   <= '0;
                    dbz_q    <= 1'b0;
                    // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
                    if (bus.Op[1]) begin
                        b_reg  <= b_mag;
                        lo_acc <= a_mag;
                    end else begin
                        b_reg  <= a_mag;
                        lo_acc <= b_mag;
                    end
                end
                ITER: if (!abort_hit && count != LAST) begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        hi_acc <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo_acc <= {lo_acc[WIDTH-2:0], div_ge};
                    end else begin
                        hi_acc <= mul_sum[WIDTH:1];
                        lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
                    end
                end
                FIX: if (!abort_hit) begin
                    dbz_q <= is_div & div_zero;
                    if (!is_div) begin
                        hi_out_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out_q <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        // Remainder path already holds |dividend|, so r_fix restores the dividend.
                        hi_out_q <= r_fix;
                        lo_out_q <= '1;
                    end else begin
                        hi_out_q <= r_fix;
                        lo_out_q <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy          = (state == ITER) || (state == FIX);
    assign bus.Done          = (state == DONE);
    assign bus.HiWriteEnable = (state == DONE);
    assign bus.LoWriteEnable = (state == DONE);
    assign bus.HiOut         = hi_out_q;
    assign bus.LoOut         = lo_out_q;
    assign bus.DivByZero     = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: results, latency, ignored Starts, reset abort.
// With MDU_ABORT_EN defined it also exercises Abort.
module tb_mult_div_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one op, scramble operands while busy, and check latency, result and strobes.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input bit inject);
        int n;
        int busy_n;
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
        @(negedge Clk);
        bus.Start = 1'b0;
        chk({tag, ".busy_at_start"}, 64'(bus.Busy), 64'd1);
        chk({tag, ".dbz_cleared"}, 64'(bus.DivByZero), 64'd0);
        n = 0;
        busy_n = 0;
        while (!bus.Done && n < 100) begin
            if (bus.Busy) busy_n++;
            bus.OperandA = $urandom;
            bus.OperandB = $urandom;
            bus.Op       = 2'($urandom_range(3));
            bus.Start    = inject && (n == 2 || n == 19);
            @(negedge Clk);
            n++;
        end
        bus.Start = 1'b0;
        chk({tag, ".latency"}, 64'(n), 64'd34);
        chk({tag, ".busy_cycles"}, 64'(busy_n), 64'd34);
        chk({tag, ".hi"}, 64'(bus.HiOut), 64'(ehi));
        chk({tag, ".lo"}, 64'(bus.LoOut), 64'(elo));
        chk({tag, ".dbz"}, 64'(bus.DivByZero), 64'(edbz));
        chk({tag, ".we_at_done"}, {62'd0, bus.HiWriteEnable, bus.LoWriteEnable}, 64'd3);
        chk({tag, ".busy_at_done"}, 64'(bus.Busy), 64'd0);
        if (inject) bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        chk({tag, ".done_pulse"}, {61'd0, bus.Done, bus.HiWriteEnable, bus.LoWriteEnable}, 64'd0);
        chk({tag, ".hold"}, {bus.HiOut, bus.LoOut}, {ehi, elo});
        if (inject) chk({tag, ".start_in_done_ignored"}, 64'(bus.Busy), 64'd0);
    endtask

    initial begin
        int strobes;
        Reset = 1'b0;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
`ifdef MDU_ABORT_EN
        bus.Abort = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("reset.flags", {59'd0, bus.Busy, bus.Done, bus.HiWriteEnable, bus.LoWriteEnable, bus.DivByZero}, 64'd0);
        chk("reset.hilo", {bus.HiOut, bus.LoOut}, 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("mult_nn",   2'b00, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000000, 32'h00000014, 1'b0, 1'b0);
        run_op("div_negd",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("div_negv",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu_7_2",  2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b0);
        run_op("divu_zero", 2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("div_zero",  2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("ign_start", 2'b01, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 2'b01; bus.OperandA = 32'd7; bus.OperandB = 32'd9;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        chk("rst_mid.busy", 64'(bus.Busy), 64'd0);
        chk("rst_mid.hilo", {bus.HiOut, bus.LoOut}, 64'd0);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done || bus.HiWriteEnable || bus.LoWriteEnable) strobes++;
            @(negedge Clk);
        end
        chk("rst_mid.no_strobe", 64'(strobes), 64'd0);
        run_op("after_rst", 2'b01, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1'b0, 1'b0);

`ifdef MDU_ABORT_EN
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = 2'b01; bus.OperandA = 32'd7; bus.OperandB = 32'd9;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge Clk);
        bus.Abort = 1'b1;
        @(negedge Clk);
        bus.Abort = 1'b0;
        chk("abort.busy", 64'(bus.Busy), 64'd0);
        chk("abort.hilo_kept", {bus.HiOut, bus.LoOut}, 64'h00000000_0000001E);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done || bus.HiWriteEnable || bus.LoWriteEnable) strobes++;
            @(negedge Clk);
        end
        chk("abort.no_strobe", 64'(strobes), 64'd0);
        run_op("after_abort", 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI and LO registers. It drives their data inputs and issues one write-enable pulse per register when a result is ready. The pipeline control stalls on Busy and launches an operation with a one-cycle Start.

Parameters:
WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset (0 = reset)
Start  input  1  launch request, sampled only in IDLE
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
OperandA  input  WIDTH  multiplicand / dividend (rs)
OperandB  input  WIDTH  multiplier / divisor (rt)
Busy  output  1  operation in progress; Start ignored while high
Done  output  1  one-cycle pulse, result valid
HiOut  output  WIDTH  to HI register data input
LoOut  output  WIDTH  to LO register data input
HiWriteEnable  output  1  HI register write strobe, equal to Done
LoWriteEnable  output  1  LO register write strobe, equal to Done
DivByZero  output  1  sticky until next Start; last DIV/DIVU had divisor 0

Behaviour:
- Reset (Reset=0 at a rising edge):
  - State goes to IDLE.
  - Busy, Done, HiWriteEnable, LoWriteEnable, DivByZero all 0.
  - HiOut and LoOut are 0.
  - Reset has priority over every other input.
- State machine:
  - IDLE -> ITER on Start=1. At this edge, latch Op and operand magnitudes (absolute values for signed ops), latch the result signs, set Busy=1, clear DivByZero.
  - ITER runs WIDTH cycles, one bit per cycle:
    - Multiply: shift-add into a 2*WIDTH product register.
    - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
  - ITER -> FIX after the WIDTH-th iteration.
  - FIX (1 cycle): apply the sign correction and register HiOut and LoOut.
  - FIX -> DONE.
  - DONE (1 cycle): Done, HiWriteEnable and LoWriteEnable are 1; Busy is 0. Next state is IDLE.
  - A Start seen in DONE is ignored; a new op is accepted only from IDLE.
- Latency:
  - Start sampled at edge k.
  - Done is high during the cycle after edge k+WIDTH+2 (edge k+34 for WIDTH=32).
  - Busy is high from edge k to edge k+WIDTH+2, exclusive.
- Results:
  - MULT and MULTU: {HiOut, LoOut} = the full 2*WIDTH product. Signed or unsigned per Op.
  - DIV and DIVU: LoOut = quotient, HiOut = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Boundaries:
  - Divisor 0 (DIV or DIVU): LoOut = all ones, HiOut = the dividend unchanged, DivByZero=1. Latency is unchanged.
  - Signed overflow (most-negative / -1): LoOut = most-negative, HiOut = 0, DivByZero=0.
  - Operands changing while Busy have no effect; they are latched at Start.
  - Reset low mid-operation: abort, no Done and no write strobes, outputs cleared.
- Between operations: HiOut and LoOut hold the last result. The strobes are 0 outside DONE.

Optional Feature:
MDU_ABORT_EN.
- Defined:
  - Adds input port Abort (1 bit).
  - Abort=1 at a rising edge while in ITER or FIX sends the state to IDLE next cycle. Busy drops, no Done, no write strobes, HiOut and LoOut keep their previous values.
  - Abort in IDLE or DONE has no effect.
  - Abort and Start together in IDLE: Start wins.
- Not defined: the Abort port is absent and an operation always runs to completion.

Test Plan:
1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001. Done and both write enables high for exactly one cycle, 34 cycles after the Start edge. Busy high for 34 cycles.
2. MULT 0xFFFFFFFD (-3) * 0x00000007 -> HiOut=0xFFFFFFFF, LoOut=0xFFFFFFEB (-21).
3. Divide pair:
   - DIV 0xFFFFFFF9 (-7) / 2 -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF.
   - Then DIVU 7 / 2 -> LoOut=3, HiOut=1.
4. Divide edge cases:
   - DIVU 0x64 / 0 -> LoOut=0xFFFFFFFF, HiOut=0x64, DivByZero=1.
   - Then DIV 0x80000000 / 0xFFFFFFFF -> LoOut=0x80000000, HiOut=0, DivByZero=0.
5. Start with MULTU 5*6. Pulse Start again with different operands at cycles 3 and 20 -> ignored; result is HiOut=0, LoOut=30. Busy stays high throughout.
6. Reset mid-operation: start MULTU 5*6, drive Reset=0 at cycle 10 -> next cycle Busy=0 and HiOut=LoOut=0. No Done or write strobe ever. A fresh Start after Reset=1 completes normally.
   - With MDU_ABORT_EN: Abort at cycle 10 -> same, except HiOut and LoOut keep their prior values.
